// File: rtl/plab2_proc_alu_tdm_arbiter_if.sv
// Bundle of the two requester channels and the shared-ALU bus for the TDM ALU arbiter.
// master = requesters plus the shared ALU; slave = the arbiter.
interface plab2_proc_alu_tdm_arbiter_if #(
  parameter int p_nbits = 32
);

  // A transfer happens on a rising edge where val && rdy. The sender holds val and its
  // payload stable until the transfer; the receiver may raise or lower rdy freely.
  logic               req0_val;
  logic               req0_rdy;
  logic [3:0]         req0_fn;
  logic [p_nbits-1:0] req0_in0;
  logic [p_nbits-1:0] req0_in1;

  logic               req1_val;
  logic               req1_rdy;
  logic [3:0]         req1_fn;
  logic [p_nbits-1:0] req1_in0;
  logic [p_nbits-1:0] req1_in1;

  logic               resp0_val;
  logic               resp0_rdy;
  logic [p_nbits-1:0] resp0_out;

  logic               resp1_val;
  logic               resp1_rdy;
  logic [p_nbits-1:0] resp1_out;

  logic               alu_domain;
  logic [3:0]         alu_fn;
  logic [p_nbits-1:0] alu_in0;
  logic [p_nbits-1:0] alu_in1;
  logic [p_nbits-1:0] alu_out;

  modport master (
    output req0_val, req0_fn, req0_in0, req0_in1,
    input  req0_rdy,
    output req1_val, req1_fn, req1_in0, req1_in1,
    input  req1_rdy,
    input  resp0_val, resp0_out,
    output resp0_rdy,
    input  resp1_val, resp1_out,
    output resp1_rdy,
    input  alu_domain, alu_fn, alu_in0, alu_in1,
    output alu_out
  );

  modport slave (
    input  req0_val, req0_fn, req0_in0, req0_in1,
    output req0_rdy,
    input  req1_val, req1_fn, req1_in0, req1_in1,
    output req1_rdy,
    output resp0_val, resp0_out,
    input  resp0_rdy,
    output resp1_val, resp1_out,
    input  resp1_rdy,
    output alu_domain, alu_fn, alu_in0, alu_in1,
    input  alu_out
  );

endinterface

// File: rtl/plab2_proc_alu_tdm_arbiter.sv
// Time-division arbiter sharing one combinational ALU between security domains 0 (L) and 1 (H).
// Optional build macro PLAB2_ALU_ARB_WORK_CONSERVING_EN lets the non-owner use idle owner slots.
module plab2_proc_alu_tdm_arbiter #(
  parameter  int p_nbits       = 32,
  parameter  int p_slot_cycles = 4,
  localparam int c_cw          = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1
) (
  input  logic            clk,
  input  logic            reset,
  plab2_proc_alu_tdm_arbiter_if.slave bus,
  output logic            dbg_owner,
  output logic [c_cw-1:0] dbg_slot_cnt
);

  localparam logic [c_cw-1:0] c_last = c_cw'(p_slot_cycles - 1);

  logic [c_cw-1:0]    slot_cnt;
  logic               owner;

  logic [1:0]         buf_val;
  logic [3:0]         buf_fn  [2];
  logic [p_nbits-1:0] buf_in0 [2];
  logic [p_nbits-1:0] buf_in1 [2];

  logic [1:0]         rsp_val;
  logic [p_nbits-1:0] rsp_out [2];

  logic [1:0]         req_val;
  logic [1:0]         req_rdy;
  logic [1:0]         req_fire;
  logic [1:0]         resp_rdy;
  logic [1:0]         resp_fire;
  logic [1:0]         can_issue;
  logic [1:0]         issue;
  logic [3:0]         req_fn  [2];
  logic [p_nbits-1:0] req_in0 [2];
  logic [p_nbits-1:0] req_in1 [2];
  logic               sel;

  assign req_val    = {bus.req1_val, bus.req0_val};
  assign resp_rdy   = {bus.resp1_rdy, bus.resp0_rdy};
  assign req_fn[0]  = bus.req0_fn;
  assign req_fn[1]  = bus.req1_fn;
  assign req_in0[0] = bus.req0_in0;
  assign req_in0[1] = bus.req1_in0;
  assign req_in1[0] = bus.req0_in1;
  assign req_in1[1] = bus.req1_in1;

  always_comb begin
    resp_fire = rsp_val & resp_rdy;
    can_issue = buf_val & (~rsp_val | resp_fire);
    issue     = 2'b00;
`ifdef PLAB2_ALU_ARB_WORK_CONSERVING_EN
    if (can_issue[owner])       issue[owner]  = 1'b1;
    else if (can_issue[!owner]) issue[!owner] = 1'b1;
`else
    // Only the slot owner may ever issue, so domain-0 timing never sees domain-1 state.
    issue[owner] = can_issue[owner];
`endif
    req_rdy  = ~buf_val | issue;
    req_fire = req_val & req_rdy;
    sel      = issue[1];
  end

  assign bus.req0_rdy  = req_rdy[0];
  assign bus.req1_rdy  = req_rdy[1];
  assign bus.resp0_val = rsp_val[0];
  assign bus.resp1_val = rsp_val[1];
  assign bus.resp0_out = rsp_out[0];
  assign bus.resp1_out = rsp_out[1];

  // Idle cycles drive zeros so no stale operand of either domain lingers on the shared wires.
  assign bus.alu_fn  = (|issue) ? buf_fn[sel]  : 4'd0;
  assign bus.alu_in0 = (|issue) ? buf_in0[sel] : '0;
  assign bus.alu_in1 = (|issue) ? buf_in1[sel] : '0;
`ifdef PLAB2_ALU_ARB_WORK_CONSERVING_EN
  assign bus.alu_domain = (|issue) ? sel : owner;
`else
  assign bus.alu_domain = owner;
`endif

  assign dbg_owner    = owner;
  assign dbg_slot_cnt = slot_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      owner    <= 1'b0;
      buf_val  <= 2'b00;
      rsp_val  <= 2'b00;
      for (int d = 0; d < 2; d++) begin
        buf_fn[d]  <= 4'd0;
        buf_in0[d] <= '0;
        buf_in1[d] <= '0;
        rsp_out[d] <= '0;
      end
    end else begin
      // The schedule free-runs regardless of traffic.
      if (slot_cnt == c_last) begin
        slot_cnt <= '0;
        owner    <= ~owner;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
        if (issue[d]) begin
          rsp_val[d] <= 1'b1;
          rsp_out[d] <= bus.alu_out;
        end else if (resp_fire[d]) begin
          rsp_val[d] <= 1'b0;
        end
        if (req_fire[d]) begin
          buf_val[d] <= 1'b1;
          buf_fn[d]  <= req_fn[d];
          buf_in0[d] <= req_in0[d];
          buf_in1[d] <= req_in1[d];
        end else if (issue[d]) begin
          buf_val[d] <= 1'b0;
        end
      end
    end
  end

endmodule
